seq_pattern_tx: RTL

Serial bit-pattern transmitter: captures a parallel pattern, its bit length and a repeat count, then drives the pattern MSB-first on a single-bit Dout stream, one bit per Clock. It produces the Din stream that the team's serial sequence-detector FSMs consume. It replaces hand-written `#delay` stimulus in detector benches and serves as the serial source in detector-based datapaths. A Start/Busy/Done handshake lets a controller or bench sequence transmissions back to back.

---
 rtl/seq_pattern_tx_if.sv | 28 ++
 rtl/seq_pattern_tx.sv | 117 +++++++++++
 2 files changed

// File: rtl/seq_pattern_tx_if.sv
// Handshake and data bundle between a pattern-transmitter controller and seq_pattern_tx.
// The controller owns the request side; the transmitter drives the serial stream and status.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             Start;
  logic             Abort;
  logic [WIDTH-1:0] Pattern;
  logic [LEN_W-1:0] Len;
  logic [CNT_W-1:0] Repeat;
  logic             IdleLevel;
  logic             Dout;
  logic             Valid;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Abort, Pattern, Len, Repeat, IdleLevel,
    input  Dout, Valid, Busy, Done
  );

  modport slave (
    input  Start, Abort, Pattern, Len, Repeat, IdleLevel,
    output Dout, Valid, Busy, Done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends Pattern[L-1:0] MSB-first, Repeat+1 times,
// with a Start/Busy/Done handshake and a one-cycle Done pulse after the last bit.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  seq_pattern_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] aligned_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [LEN_W-1:0] len_m1_reg;
  logic [LEN_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0] rep_cnt_reg;
  logic             dout_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [LEN_W-1:0] len_clamped;
  logic [WIDTH-1:0] aligned_next;

  // The used field is left-justified so the next bit is always the register MSB.
  always_comb begin
    len_clamped = bus.Len;
    if (bus.Len == '0 || bus.Len > LEN_W'(WIDTH)) begin
      len_clamped = LEN_W'(WIDTH);
    end
    aligned_next = bus.Pattern << (LEN_W'(WIDTH) - len_clamped);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      aligned_reg <= '0;
      shift_reg   <= '0;
      len_m1_reg  <= '0;
      bit_cnt_reg <= '0;
      rep_cnt_reg <= '0;
      dout_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          dout_reg  <= bus.IdleLevel;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          if (bus.Start) begin
            aligned_reg <= aligned_next;
            shift_reg   <= aligned_next << 1;
            len_m1_reg  <= len_clamped - 1'b1;
            bit_cnt_reg <= len_clamped - 1'b1;
            rep_cnt_reg <= bus.Repeat;
            dout_reg    <= aligned_next[WIDTH-1];
            valid_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end

        SHIFT: begin
          if (bus.Abort) begin
            state_reg <= IDLE;
            dout_reg  <= bus.IdleLevel;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end else if (bit_cnt_reg != '0) begin
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
            dout_reg    <= shift_reg[WIDTH-1];
            shift_reg   <= shift_reg << 1;
          end else if (rep_cnt_reg != '0) begin
            // Reload the captured field so repetitions follow with no gap.
            rep_cnt_reg <= rep_cnt_reg - 1'b1;
            bit_cnt_reg <= len_m1_reg;
            dout_reg    <= aligned_reg[WIDTH-1];
            shift_reg   <= aligned_reg << 1;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            dout_reg  <= bus.IdleLevel;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          dout_reg  <= bus.IdleLevel;
        end

        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          dout_reg  <= bus.IdleLevel;
        end
      endcase
    end
  end

  assign bus.Dout  = dout_reg;
  assign bus.Valid = valid_reg;
  assign bus.Busy  = busy_reg;
  assign bus.Done  = done_reg;
endmodule
